fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the main decoder. It holds the PC and issues word requests to instruction memory over a valid/ready channel. Returned instructions are buffered in a small in-order FIFO and presented to decode with a valid/ready handshake. Branch and jump redirects from execute flush the buffer and discard any in-flight responses.

Parameters:
XLEN, 32, address and instruction width
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries; also the cap on buffered plus in-flight fetches (power of two, at least 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  word-aligned fetch address
imem_resp_valid  input  1  response data valid; in order, one per accepted request, never in the acceptance cycle
imem_resp_data  input  XLEN  fetched instruction word
redirect_valid  input  1  branch/jump taken; load new PC
redirect_pc  input  XLEN  redirect target
dec_valid  output  1  instruction available to decoder
dec_ready  input  1  decoder consumes instruction
dec_instr  output  XLEN  instruction to decoder
dec_pc  output  XLEN  PC of dec_instr

Behaviour:
- Reset (rst_n low at a clk edge):
  - pc = RESET_PC; FIFO empty; inflight = 0; kill = 0.
  - imem_req_valid, dec_valid = 0; dec_instr, dec_pc = 0.
- Request issue:
  - imem_req_valid = (inflight + fifo_count < FIFO_DEPTH) and not redirect_valid. This guarantees every response has a FIFO slot, so no backpressure on responses is ever needed.
  - imem_req_addr = pc.
  - On req handshake: pc += 4; inflight += 1.
  - imem_req_valid, once raised, holds with a stable address until accepted or a redirect occurs.
- Response handling:
  - Each imem_resp_valid decrements inflight.
  - If kill > 0: kill -= 1 and the data is dropped.
  - Otherwise push {data, address} into the FIFO. The address comes from a parallel PC queue, or from a response-PC register advanced by 4 per non-killed push.
- Decode side:
  - dec_valid = FIFO non-empty, registered; no same-cycle bypass from imem_resp.
  - dec_instr / dec_pc = FIFO head.
  - Pop on dec_valid and dec_ready.
  - dec_instr / dec_pc hold stable while dec_valid is high and dec_ready is low.
- Redirect (redirect_valid = 1 in cycle N):
  - pc = {redirect_pc[XLEN-1:2], 2'b00}; low bits are forced to zero and no misalignment exception is raised.
  - FIFO flushed at the edge ending N; dec_valid = 0 in N+1.
  - No request in N.
  - kill = inflight minus (imem_resp_valid in N ? 1 : 0), and the response arriving in N is itself dropped.
  - First request to the new PC appears in N+1.
- Simultaneous events:
  - Redirect and dec handshake in the same cycle: the handshake completes (decoder took the instruction), then the flush applies.
  - Push and pop in the same cycle: count unchanged.
  - A redirect while kill > 0 adds the remaining inflight to kill; no double count.
- Latency, with 1-cycle memory and always-ready decode:
  - rst_n rises before edge 0; request accepted in cycle 0; response in cycle 1; dec_valid in cycle 2.
  - Steady state: one instruction per cycle.
- Counters:
  - inflight and kill are clog2(FIFO_DEPTH)+1 bits; neither may underflow.
  - A response while inflight = 0 is a protocol error; it is flagged by an assertion only.

Decomposition:
- Shared package rv_pkg: XLEN, RESET_PC, INSTR_BYTES = 4, NOP = 32'h0000_0013.
- One sub-module, fetch_fifo: synchronous FIFO (parameters WIDTH, DEPTH) with push, pop, flush, empty, full, count. Entry width is 2*XLEN (instr + pc).
- Counters and PC logic stay in fetch_unit.

Test Plan:
- Reset, then 1-cycle memory returning 32'h00000013 at every address with dec_ready = 1 → dec_pc = 0x0, 0x4, 0x8 on consecutive cycles starting cycle 2; dec_valid low during and one cycle after reset.
- dec_ready held low for 5 cycles → after FIFO fills (2 entries), imem_req_valid = 0. Release → dec_pc continues 0x0, 0x4, 0x8 with no gaps or duplicates.
- With 2 fetches in flight, redirect_valid, redirect_pc = 0x100 → both stale responses dropped, next request address 0x100, first dec_pc = 0x100, dec_valid low in between.
- redirect_pc = 0x103 → imem_req_addr = 0x100.
- Redirect in the same cycle as a dec handshake and an imem response → the handshaked instruction is counted as consumed, the response is dropped, the next dec_pc is the target, and kill returns to 0.
- rst_n asserted mid-stream with 2 in flight and a full FIFO → next cycle all outputs 0 and the first request is to RESET_PC; the memory model is reset alongside.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch-path constants: datapath width, reset vector, instruction size.
// Imported by the fetch stage and its buffer.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer: write at tail, read at head, flush clears both pointers.
// Head is visible the cycle after a push; push into a full FIFO is only honoured alongside a pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign count     = cnt;
  assign head_data = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, memory request issue, response buffering and redirect flush.
// Decode sees a response 1 cycle after it returns; requests stall when buffer plus in-flight is full.
module fetch_unit #(
  parameter int              XLEN       = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = rv_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
);

  import rv_pkg::*;

  localparam int              CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   inflight_dec;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   kill_q;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            fifo_empty;
  logic            fifo_full;
  logic            req_hs;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head_entry;

  assign target_pc = redirect_pc & ~XLEN'(3);
  assign pop       = !fifo_empty && dec_ready;

  // A slot freed by this cycle's pop is already gone before any new response
  // can land, so it counts as free; this keeps one instruction per cycle at depth 2.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, fifo_count} - (CW+1)'(pop);
  assign imem_req_valid = rst_n && !redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  // Responses landing in a redirect cycle belong to the old stream.
  assign push       = imem_resp_valid && (kill_q == '0) && !redirect_valid;
  assign push_entry = '{instr: imem_resp_data, pc: resp_pc_q};

  always_comb begin
    inflight_dec = inflight_q;
    if (imem_resp_valid && (inflight_q != '0)) inflight_dec = inflight_q - 1'b1;
    inflight_nxt = inflight_dec + CW'(req_hs);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      kill_q     <= '0;
    end else begin
      inflight_q <= inflight_nxt;
      if (redirect_valid) begin
        pc_q      <= target_pc;
        resp_pc_q <= target_pc;
        kill_q    <= inflight_dec;
      end else begin
        if (req_hs) pc_q <= pc_q + STEP;
        if (push)   resp_pc_q <= resp_pc_q + STEP;
        if (imem_resp_valid && (kill_q != '0)) kill_q <= kill_q - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign dec_valid = !fifo_empty;
  assign dec_instr = fifo_empty ? '0 : head_entry.instr;
  assign dec_pc    = fifo_empty ? '0 : head_entry.pc;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_resp_valid && (inflight_q == '0)));
      assert (!(push && fifo_full && !pop));
    end
  end

endmodule
